stream_eval_controller: RTL and testbench
=========================================

STREAM_EVAL_CONTROLLER -- requirements
Module: stream_eval_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 64, lines processed per run; legal range 1..2**IDX_W.
REQ-002 SHALL have parameter IDX_W, default 6, width of line_index.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the current run.
REQ-007 SHALL have port cal_done  input  1  datapath calculation complete.
REQ-008 SHALL have port wr_ready  input  1  file writer accepts the current line.
REQ-009 SHALL have port clr  output  1  synchronous datapath clear.
REQ-010 SHALL have port read_file  output  1  load input file.
REQ-011 SHALL have port write_reg  output  1  latch line line_index into datapath registers.
REQ-012 SHALL have port write_file  output  1  result for line_index valid for writing.
REQ-013 SHALL have port line_index  output  IDX_W  current line number.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port finish  output  1  one-cycle pulse on run completion.

Function
REQ-016 States: IDLE, INIT, READ, REG_WRITE, CAL, WRITE, DONE; all control outputs Moore-decoded from state alone.
REQ-017 IDLE: start=1 -> INIT; else stay.
REQ-018 INIT: clr=1, read_file=1, line counter loaded with 0; -> READ.
REQ-019 READ: no outputs; -> REG_WRITE.
REQ-020 REG_WRITE: write_reg=1; -> CAL.
REQ-021 CAL: hold until cal_done=1, then -> WRITE; cal_done is ignored in all other states.
REQ-022 WRITE: write_file=1 every cycle until wr_ready=1; on that edge, if line_index==NUM_LINES-1 -> DONE, else increment the counter and -> REG_WRITE.
REQ-023 DONE: finish=1; -> IDLE.
REQ-024 line_index SHALL equal the counter; it is stable from REG_WRITE through the accepting WRITE cycle.
REQ-025 Counter arithmetic is IDX_W-bit unsigned; it never exceeds NUM_LINES-1 and never wraps during a run.
REQ-026 abort=1 in any state other than IDLE -> IDLE on the next edge; the counter is cleared and finish is not asserted.
REQ-027 abort takes priority over cal_done, wr_ready and the terminal-count check when they occur in the same cycle.
REQ-028 start while busy is ignored; start held high in DONE does not restart until IDLE is reached.
REQ-029 With cal_done=wr_ready=1 and start sampled in cycle 0, INIT is in cycle 1, line k is in REG_WRITE in cycle 3+3k, and finish is high in cycle 3*NUM_LINES+3.
REQ-030 NUM_LINES=1: exactly one REG_WRITE/CAL/WRITE pass, then DONE.

Reset
REQ-031 rst=1 SHALL force state IDLE and counter 0 immediately, independent of clk.
REQ-032 While rst=1 and after its release, all outputs SHALL be 0 until start is sampled.
REQ-033 rst asserted mid-run SHALL abandon the run without a finish pulse.

Structure
REQ-034 State encodings (3-bit) SHALL live in the shared package eval_ctrl_pkg, together with the default NUM_LINES and IDX_W.
REQ-035 The line counter SHALL be a sub-module line_counter (inputs clear and inc; output terminal = count==NUM_LINES-1), instantiated once.
REQ-036 Parameter legality (NUM_LINES<1 or >2**IDX_W) SHALL be rejected at elaboration.

Verification
REQ-037 NUM_LINES=4, cal_done=wr_ready=1, start pulse in cycle 0 -> write_reg in cycles 3,6,9,12 with line_index 0..3; finish in cycle 15 only.
REQ-038 cal_done delayed 5 cycles for line 2 -> CAL held 5 cycles; line_index stays 2; write_file rises only afterwards.
REQ-039 wr_ready low 3 cycles on line 0 -> write_file high 4 consecutive cycles; counter advances once.
REQ-040 abort together with wr_ready on the last line -> IDLE next cycle, no finish, line_index=0, busy=0.
REQ-041 rst pulse mid-CAL, asynchronous to clk -> outputs 0 immediately; a new start then yields a complete run from line 0.
REQ-042 NUM_LINES=1, IDX_W=1 -> single line 0 processed; finish in cycle 6; start held high during the run causes no second run before IDLE.

Source files
------------

// File: rtl/eval_ctrl_pkg.sv
// Shared types and defaults for the stream evaluation controller.
// Pure declarations: no latency, no flow control.
package eval_ctrl_pkg;

    localparam int DEF_NUM_LINES = 64;
    localparam int DEF_IDX_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_READ      = 3'd2,
        ST_REG_WRITE = 3'd3,
        ST_CAL       = 3'd4,
        ST_WRITE     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/stream_eval_controller_if.sv
// Control/handshake bundle between the evaluation controller and its datapath/file writer.
// Wiring only: no latency; wr_ready is the writer's backpressure into the controller.
interface stream_eval_controller_if
    import eval_ctrl_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
);
    logic             start;
    logic             abort;
    logic             cal_done;
    logic             wr_ready;
    logic             clr;
    logic             read_file;
    logic             write_reg;
    logic             write_file;
    logic [IDX_W-1:0] line_index;
    logic             busy;
    logic             finish;

    // master is the controller side
    modport master (
        input  start, abort, cal_done, wr_ready,
        output clr, read_file, write_reg, write_file, line_index, busy, finish
    );

    modport slave (
        output start, abort, cal_done, wr_ready,
        input  clr, read_file, write_reg, write_file, line_index, busy, finish
    );
endinterface

// File: rtl/line_counter.sv
// Saturating line counter: clear has priority, inc stops at NUM_LINES-1; 1-cycle update.
// No backpressure; terminal is combinational from the current count.
module line_counter #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             terminal
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LINES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !terminal) begin
            count <= count + IDX_W'(1);
        end
    end

    assign terminal = (count == LAST);
endmodule

// File: rtl/stream_eval_controller.sv
// Sequences clear/read, then per line REG_WRITE -> CAL -> WRITE, then a finish pulse; Moore outputs.
// Stalls in CAL until cal_done and in WRITE until wr_ready; abort returns to IDLE next edge.
module stream_eval_controller
    import eval_ctrl_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_eval_controller_if.master ctl
);
    generate
        if (NUM_LINES < 1 || NUM_LINES > (1 << IDX_W)) begin : g_bad_params
            $error("stream_eval_controller: NUM_LINES out of range for IDX_W");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_terminal;
    logic [IDX_W-1:0] cnt;

    line_counter #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_line_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .count    (cnt),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort is checked before any per-state condition so it wins every tie
    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (state != ST_IDLE && ctl.abort) begin
            state_nxt = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE:      if (ctl.start) state_nxt = ST_INIT;
                ST_INIT: begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_READ;
                end
                ST_READ:      state_nxt = ST_REG_WRITE;
                ST_REG_WRITE: state_nxt = ST_CAL;
                ST_CAL:       if (ctl.cal_done) state_nxt = ST_WRITE;
                ST_WRITE: begin
                    if (ctl.wr_ready) begin
                        if (cnt_terminal) begin
                            state_nxt = ST_DONE;
                        end else begin
                            cnt_inc   = 1'b1;
                            state_nxt = ST_REG_WRITE;
                        end
                    end
                end
                ST_DONE:      state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    assign ctl.clr        = (state == ST_INIT);
    assign ctl.read_file  = (state == ST_INIT);
    assign ctl.write_reg  = (state == ST_REG_WRITE);
    assign ctl.write_file = (state == ST_WRITE);
    assign ctl.busy       = (state != ST_IDLE);
    assign ctl.finish     = (state == ST_DONE);
    assign ctl.line_index = cnt;
endmodule

// File: tb/tb_stream_eval_controller.sv
// Directed checks of the evaluation controller: a 4-line instance and a 1-line instance.
module tb_stream_eval_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stream_eval_controller_if #(.IDX_W(6)) bus_a ();
    stream_eval_controller_if #(.IDX_W(1)) bus_b ();

    stream_eval_controller #(.NUM_LINES(4), .IDX_W(6)) dut_a (
        .clk (clk),
        .rst (rst),
        .ctl (bus_a)
    );

    stream_eval_controller #(.NUM_LINES(1), .IDX_W(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .ctl (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, " clr"},        32'(bus_a.clr),        32'd0);
        check({tag, " read_file"},  32'(bus_a.read_file),  32'd0);
        check({tag, " write_reg"},  32'(bus_a.write_reg),  32'd0);
        check({tag, " write_file"}, 32'(bus_a.write_file), 32'd0);
        check({tag, " busy"},       32'(bus_a.busy),       32'd0);
        check({tag, " finish"},     32'(bus_a.finish),     32'd0);
        check({tag, " line_index"}, 32'(bus_a.line_index), 32'd0);
    endtask

    // cycle c is the cycle before posedge c; start is driven high only in cycle 0
    task automatic run_a(input string name, input int ncyc,
                         input logic [63:0] cal_m, input logic [63:0] wr_m, input logic [63:0] ab_m,
                         input logic [63:0] e_wreg, input logic [63:0] e_wfile,
                         input logic [63:0] e_fin, input logic [63:0] e_busy);
        int n;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus_a.start    = (c == 0);
            bus_a.cal_done = cal_m[c];
            bus_a.wr_ready = wr_m[c];
            bus_a.abort    = ab_m[c];
            check($sformatf("%s c%0d write_reg", name, c),  32'(bus_a.write_reg),  32'(e_wreg[c]));
            check($sformatf("%s c%0d write_file", name, c), 32'(bus_a.write_file), 32'(e_wfile[c]));
            check($sformatf("%s c%0d finish", name, c),     32'(bus_a.finish),     32'(e_fin[c]));
            check($sformatf("%s c%0d busy", name, c),       32'(bus_a.busy),       32'(e_busy[c]));
            check($sformatf("%s c%0d clr", name, c),        32'(bus_a.clr),        32'(c == 1));
            check($sformatf("%s c%0d read_file", name, c),  32'(bus_a.read_file),  32'(c == 1));
            n = 0;
            for (int j = 0; j <= c; j++) if (e_wreg[j]) n++;
            if (e_busy[c] && c >= 3)
                check($sformatf("%s c%0d line_index", name, c), 32'(bus_a.line_index), 32'(n - 1));
        end
        bus_a.abort    = 1'b0;
        bus_a.cal_done = 1'b1;
        bus_a.wr_ready = 1'b1;
    endtask

    initial begin
        logic [63:0] b_busy, b_wreg, b_wfile, b_fin, b_clr;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.cal_done = 1'b1; bus_a.wr_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.cal_done = 1'b1; bus_b.wr_ready = 1'b1;

        #3;
        check_a_quiet("reset_async");
        repeat (2) @(negedge clk);
        check_a_quiet("reset_held");
        check("reset_held b busy", 32'(bus_b.busy), 32'd0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_a_quiet("after_release");

        // back-to-back lines, no stalls
        run_a("basic", 18, '1, '1, '0,
              64'h1248, 64'h4920, 64'h8000, 64'hFFFE);

        // line 2 held in CAL for cycles 10..14
        run_a("cal_stall", 22, 64'hFFFF_FFFF_FFFF_C3FF, '1, '0,
              64'h1_0248, 64'h4_8120, 64'h8_0000, 64'hF_FFFE);

        // writer stalls line 0 for cycles 5..7
        run_a("wr_stall", 21, '1, 64'hFFFF_FFFF_FFFF_FF1F, '0,
              64'h9208, 64'h2_49E0, 64'h4_0000, 64'h7_FFFE);

        // abort coincides with wr_ready on the last line
        run_a("abort_last", 18, '1, '1, 64'h4000,
              64'h1248, 64'h4920, 64'h0, 64'h7FFE);
        check("abort_last line_index", 32'(bus_a.line_index), 32'd0);
        check("abort_last busy", 32'(bus_a.busy), 32'd0);

        // single-line instance with start held high throughout
        b_busy = 64'h17E; b_wreg = 64'h8; b_wfile = 64'h20; b_fin = 64'h40; b_clr = 64'h102;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus_b.start = 1'b1;
            check($sformatf("single c%0d busy", c),       32'(bus_b.busy),       32'(b_busy[c]));
            check($sformatf("single c%0d write_reg", c),  32'(bus_b.write_reg),  32'(b_wreg[c]));
            check($sformatf("single c%0d write_file", c), 32'(bus_b.write_file), 32'(b_wfile[c]));
            check($sformatf("single c%0d finish", c),     32'(bus_b.finish),     32'(b_fin[c]));
            check($sformatf("single c%0d clr", c),        32'(bus_b.clr),        32'(b_clr[c]));
            if (c == 3 || c == 5)
                check($sformatf("single c%0d line_index", c), 32'(bus_b.line_index), 32'd0);
        end
        bus_b.start = 1'b0;

        // async reset while line 1 sits in CAL
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus_a.start    = (c == 0);
            bus_a.cal_done = (c < 7);
        end
        #1;
        check("midcal busy", 32'(bus_a.busy), 32'd1);
        check("midcal line_index", 32'(bus_a.line_index), 32'd1);
        check("midcal write_reg", 32'(bus_a.write_reg), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_a_quiet("midcal_rst");
        @(negedge clk);
        check_a_quiet("midcal_rst_held");
        #2 rst = 1'b0;
        bus_a.cal_done = 1'b1;
        run_a("rerun", 18, '1, '1, '0,
              64'h1248, 64'h4920, 64'h8000, 64'hFFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
